// File: rtl/number_pkg.sv
// Shared encodings and limits for the digit/number conversion blocks.
package number_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } num_state_t;

   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam int         DIGITS_MAX = 4;
   localparam int         CNT_W      = $clog2(DIGITS_MAX + 1);

endpackage

// File: rtl/bcd_mac_step.sv
// One conversion step: sum = acc*10 + digit, flagged when it exceeds the OUT_W range.
module bcd_mac_step #(
   parameter int OUT_W = 8
) (
   input  logic [OUT_W+3:0] acc,
   input  logic [3:0]       digit,
   output logic [OUT_W+3:0] sum,
   output logic             ovf
);

   localparam logic [OUT_W+3:0] LIMIT = {4'h0, {OUT_W{1'b1}}};

   // Shift-add avoids a multiplier; acc <= 2^OUT_W-1 keeps the result inside OUT_W+4 bits.
   assign sum = (acc << 3) + (acc << 1) + {{OUT_W{1'b0}}, digit};
   assign ovf = (sum > LIMIT);

endmodule

// File: rtl/digit_to_number_module.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
// Optional nibble validity check is enabled by defining DIGIT_CHECK_EN.
module digit_to_number_module
   import number_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter int OUT_W  = 8
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic                  Start_Sig,
   input  logic [4*DIGITS-1:0]   Digit_Data,
   output logic [OUT_W-1:0]      Number_Data,
   output logic                  Done_Sig,
   output logic                  Busy_Sig,
   output logic                  Ovf_Sig,
   output logic                  Err_Sig
);

   num_state_t          state, state_nxt;
   logic [4*DIGITS-1:0] shadow;
   logic [OUT_W+3:0]    acc, step_sum;
   logic [CNT_W-1:0]    cnt;
   logic                ovf_q, step_ovf, start_acc;

   bcd_mac_step #(.OUT_W(OUT_W)) u_step (
      .acc   (acc),
      .digit (shadow[4*DIGITS-1 -: 4]),
      .sum   (step_sum),
      .ovf   (step_ovf)
   );

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // The Done cycle still counts as busy, so a new request is only taken one cycle later.
   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      case (state)
         ST_IDLE:  if (Start_Sig && !Done_Sig) begin
                      state_nxt = ST_ACCUM;
                      start_acc = 1'b1;
                   end
         ST_ACCUM: if (cnt == CNT_W'(DIGITS - 1)) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign Busy_Sig = (state != ST_IDLE) || Done_Sig;

`ifdef DIGIT_CHECK_EN
   logic err_q, bad_nibble;

   always_comb begin
      bad_nibble = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (Digit_Data[4*i +: 4] > BCD_MAX) bad_nibble = 1'b1;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)          err_q <= 1'b0;
      else if (start_acc) err_q <= bad_nibble;
   end
`endif

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         shadow      <= '0;
         acc         <= '0;
         cnt         <= '0;
         ovf_q       <= 1'b0;
         Number_Data <= '0;
         Done_Sig    <= 1'b0;
         Ovf_Sig     <= 1'b0;
         Err_Sig     <= 1'b0;
      end else begin
         Done_Sig <= 1'b0;
         if (start_acc) begin
            shadow <= Digit_Data;
            acc    <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
         end else if (state == ST_ACCUM) begin
            if (!ovf_q) begin
               acc   <= step_sum;
               ovf_q <= step_ovf;
            end
            shadow <= shadow << 4;
            cnt    <= cnt + 1'b1;
         end else if (state == ST_DONE) begin
            Done_Sig    <= 1'b1;
            Number_Data <= ovf_q ? {OUT_W{1'b1}} : acc[OUT_W-1:0];
            Ovf_Sig     <= ovf_q;
`ifdef DIGIT_CHECK_EN
            Err_Sig     <= err_q;
            if (err_q) begin
               Number_Data <= '0;
               Ovf_Sig     <= 1'b0;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_digit_to_number_module.sv
// Directed bench for digit_to_number_module: 2-digit and 3-digit instances on one clock.
module tb_digit_to_number_module;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic        start2, start3;
   logic [7:0]  digit2;
   logic [11:0] digit3;
   logic [7:0]  num2, num3;
   logic        done2, busy2, ovf2, err2;
   logic        done3, busy3, ovf3, err3;

   int n_cmp = 0;
   int n_bad = 0;
   int lat;
   int pulses;

   always #5 CLK = ~CLK;

   digit_to_number_module #(.DIGITS(2), .OUT_W(8)) dut2 (
      .CLK(CLK), .RSTn(RSTn), .Start_Sig(start2), .Digit_Data(digit2),
      .Number_Data(num2), .Done_Sig(done2), .Busy_Sig(busy2),
      .Ovf_Sig(ovf2), .Err_Sig(err2));

   digit_to_number_module #(.DIGITS(3), .OUT_W(8)) dut3 (
      .CLK(CLK), .RSTn(RSTn), .Start_Sig(start3), .Digit_Data(digit3),
      .Number_Data(num3), .Done_Sig(done3), .Busy_Sig(busy3),
      .Ovf_Sig(ovf3), .Err_Sig(err3));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Counts edges until the chosen instance pulses Done; gives up after 20 edges (lat = -1).
   task automatic wait_done(input int which, input int start_lat, output int l);
      l = -1;
      for (int i = start_lat + 1; i <= 20; i++) begin
         step();
         if ((which == 2 && done2) || (which == 3 && done3)) begin
            l = i;
            break;
         end
      end
   endtask

   task automatic start2_with(input logic [7:0] d);
      start2 = 1'b1; digit2 = d;
      step();
      start2 = 1'b0;
   endtask

   task automatic start3_with(input logic [11:0] d);
      start3 = 1'b1; digit3 = d;
      step();
      start3 = 1'b0;
   endtask

   initial begin
      RSTn = 1'b0; start2 = 1'b0; start3 = 1'b0; digit2 = '0; digit3 = '0;
      #12;
      check("rst_num",  32'(num2),  0);
      check("rst_done", 32'(done2), 0);
      check("rst_busy", 32'(busy2), 0);
      check("rst_ovf",  32'(ovf2),  0);
      check("rst_err",  32'(err2),  0);
      step();
      RSTn = 1'b1;
      step();

      // 47: accept edge, then Done three edges later
      start2_with(8'h47);
      check("busy_after_accept", 32'(busy2), 1);
      wait_done(2, 0, lat);
      check("lat_47", 32'(lat), 3);
      check("num_47", 32'(num2), 47);
      check("ovf_47", 32'(ovf2), 0);
      check("busy_in_done", 32'(busy2), 1);

      // back-to-back 99 then 00
      step();
      check("idle_busy_low", 32'(busy2), 0);
      check("idle_done_low", 32'(done2), 0);
      check("hold_47", 32'(num2), 47);
      start2_with(8'h99);
      check("busy_99", 32'(busy2), 1);
      wait_done(2, 0, lat);
      check("lat_99", 32'(lat), 3);
      check("num_99", 32'(num2), 99);
      step();
      check("gap_busy_low", 32'(busy2), 0);
      start2_with(8'h00);
      wait_done(2, 0, lat);
      check("lat_00", 32'(lat), 3);
      check("num_00", 32'(num2), 0);
      step();

      // second Start during ACCUM is dropped
      start2_with(8'h47);
      start2 = 1'b1; digit2 = 8'h12;
      step();
      start2 = 1'b0;
      wait_done(2, 1, lat);
      check("lat_ignore", 32'(lat), 3);
      check("num_ignore", 32'(num2), 47);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (done2) pulses++;
      end
      check("no_extra_done", 32'(pulses), 0);

      // 3-digit saturation boundary
      start3_with(12'h256);
      wait_done(3, 0, lat);
      check("lat_256", 32'(lat), 4);
      check("num_256", 32'(num3), 255);
      check("ovf_256", 32'(ovf3), 1);
      step();
      start3_with(12'h255);
      wait_done(3, 0, lat);
      check("num_255", 32'(num3), 255);
      check("ovf_255", 32'(ovf3), 0);
      step();

      // reset mid-conversion clears outputs at once, no Done follows
      start2_with(8'h47);
      check("busy_pre_rst", 32'(busy2), 1);
      RSTn = 1'b0;
      #1;
      check("arst_num",  32'(num2),  0);
      check("arst_busy", 32'(busy2), 0);
      check("arst_num3", 32'(num3),  0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (done2) pulses++;
      end
      check("arst_no_done", 32'(pulses), 0);
      RSTn = 1'b1;
      step();
      start2_with(8'h30);
      wait_done(2, 0, lat);
      check("lat_30", 32'(lat), 3);
      check("num_30", 32'(num2), 30);
      step();

      // non-decimal nibble
      start2_with(8'h4B);
      wait_done(2, 0, lat);
`ifdef DIGIT_CHECK_EN
      check("num_4B", 32'(num2), 0);
      check("err_4B", 32'(err2), 1);
      check("ovf_4B", 32'(ovf2), 0);
`else
      check("num_4B", 32'(num2), 51);
      check("err_4B", 32'(err2), 0);
`endif
      check("lat_4B", 32'(lat), 3);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
